mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//  Upstream controller for the 4:1 mux stage. Drives the mux select and enable to scan
//  channels 0..3 in order and samples the mux output once per channel.
//  Packs the four samples into a 4-bit frame and hands it downstream on a valid/ready handshake.
//  Sits between control logic (start/cont) and the combinational 4:1 mux.
// PARAMETERS
//  DWELL  2  cycles the select is held on each channel; legal range 1..255
//  CNT_W  8  width of the dwell counter; must satisfy 2**CNT_W > DWELL
// PORTS
//  clk          in   1  single clock; all state changes on its rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  start        in   1  begin one scan; sampled only in IDLE
//  cont         in   1  1 = rescan automatically after each frame is accepted
//  mux_s        out  2  select to the 4:1 mux (S)
//  mux_e        out  1  enable to the 4:1 mux (E)
//  mux_y        in   1  mux output (Y), sampled combinationally
//  frame_data   out  4  bit i = sample of channel i
//  frame_valid  out  1  frame_data valid; held until accepted
//  frame_ready  in   1  downstream accepts when frame_valid & frame_ready at a clock edge
//  busy         out  1  1 in SCAN or HOLD
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; mux_s=0, mux_e=0, frame_data=0, frame_valid=0, busy=0.
//   - Dwell counter, channel index and partial sample register cleared.
//   - Reset during SCAN/HOLD discards the partial or pending frame.
//  FSM:
//   - IDLE -> SCAN: on an edge with start=1. ch=0, cnt=0.
//   - SCAN: mux_e=1, mux_s=ch. cnt counts 0..DWELL-1.
//     - On an edge with cnt==DWELL-1: store mux_y into bit ch, cnt=0, ch=ch+1.
//     - When ch==3 at that edge, load frame_data (bit 3 = current mux_y), set frame_valid=1,
//       and go to HOLD.
//   - HOLD: mux_e=0, mux_s=0; frame_data and frame_valid stable.
//     - On an edge with frame_ready=1: frame_valid=0.
//     - If cont=1 go to SCAN with ch=0, cnt=0; else go to IDLE.
//  Timing:
//   - start seen at edge t0: channel i is sampled at edge t0+(i+1)*DWELL.
//   - frame_valid rises at edge t0+4*DWELL.
//   - After acceptance at edge ta (cont=1): next frame_valid at ta+4*DWELL.
//  Handshake:
//   - frame_valid never drops without acceptance; frame_data never changes while frame_valid=1.
//   - frame_ready while frame_valid=0 has no effect.
//  Corner cases:
//   - start in SCAN or HOLD is ignored (no restart, no queueing).
//   - cont is sampled only at the HOLD accept edge.
//   - DWELL=1: one channel per cycle; frame every 4 cycles plus handshake.
//   - Channel index is 2 bits and wraps naturally; it is always reset to 0 on SCAN entry.
// TESTING
//  1. DWELL=2, mux model I=4'b1010, start pulse at t0, frame_ready=1
//     -> mux_s sequence 0,0,1,1,2,2,3,3; frame_valid at t0+8; frame_data=4'b1010; then IDLE.
//  2. Backpressure: frame_ready=0 for 5 cycles after valid
//     -> frame_valid and frame_data held; mux_e=0; accepted on the first ready edge.
//  3. cont=1, I=4'b0110 then I=4'b1001 after the first accept
//     -> frames 4'b0110 then 4'b1001, each 8 cycles after the previous accept.
//  4. rst_n=0 mid-SCAN (during ch=2)
//     -> all outputs 0 immediately; after release, no frame appears until a new start.
//  5. start pulsed during SCAN and during HOLD -> no effect on timing or data.
//  6. DWELL=1 build, I=4'b1111 -> frame_valid at t0+4, frame_data=4'b1111.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scans a 4:1 mux over channels 0..3, one sample per channel after a dwell,
// and hands the packed 4-bit frame downstream on a valid/ready handshake.
module mux_scan_sequencer #(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    output logic [1:0] mux_s,
    output logic       mux_e,
    input  logic       mux_y,
    output logic [3:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_e           state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       samp_q, samp_d;
    logic [3:0]       frame_q, frame_d;
    logic             valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            cnt_q   <= '0;
            samp_q  <= 4'd0;
            frame_q <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            samp_q  <= samp_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        samp_d  = samp_q;
        frame_d = frame_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    ch_d    = 2'd0;
                    cnt_d   = '0;
                    samp_d  = 4'd0;
                end
            end
            SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    ch_d           = ch_q + 2'd1;
                    samp_d[ch_q]   = mux_y;
                    // Last channel goes straight into the frame, not via samp_q
                    if (ch_q == 2'd3) begin
                        frame_d = samp_d;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (frame_ready) begin
                    valid_d = 1'b0;
                    ch_d    = 2'd0;
                    cnt_d   = '0;
                    samp_d  = 4'd0;
                    state_d = cont ? SCAN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mux_e       = (state_q == SCAN);
    assign mux_s       = mux_e ? ch_q : 2'd0;
    assign busy        = (state_q != IDLE);
    assign frame_data  = frame_q;
    assign frame_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: DWELL=2 and DWELL=1 instances, each driving
// a behavioural 4:1 mux; frames for the main instance go through a scoreboard.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, cont, frame_ready;
    logic [3:0] in_bits;
    logic [1:0] mux_s;
    logic       mux_e, mux_y;
    logic [3:0] frame_data;
    logic       frame_valid, busy;

    logic       start1, ready1;
    logic [3:0] in1;
    logic [1:0] mux_s1;
    logic       mux_e1, mux_y1;
    logic [3:0] frame_data1;
    logic       frame_valid1, busy1;

    int n_chk  = 0;
    int n_pass = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    assign mux_y  = mux_e  ? in_bits[mux_s] : 1'b0;
    assign mux_y1 = mux_e1 ? in1[mux_s1]    : 1'b0;

    mux_scan_sequencer #(.DWELL(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
        .mux_s(mux_s), .mux_e(mux_e), .mux_y(mux_y),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .busy(busy)
    );

    mux_scan_sequencer #(.DWELL(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cont(1'b0),
        .mux_s(mux_s1), .mux_e(mux_e1), .mux_y(mux_y1),
        .frame_data(frame_data1), .frame_valid(frame_valid1),
        .frame_ready(ready1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_v(input int which, input int pulse_at, output int n);
        n = 0;
        while (n < 100 && ((which == 0 && !frame_valid) ||
                           (which == 1 && !frame_valid1))) begin
            if (which == 0) start = (n == pulse_at);
            step();
            n++;
        end
        start = 1'b0;
    endtask

    // Scoreboard pop on accept, plus hold-stability of a pending frame
    logic       pv   = 1'b0;
    logic       pacc = 1'b0;
    logic [3:0] pd   = 4'd0;
    always @(negedge clk) begin
        if (rst_n && pv && !pacc) begin
            chk("hold_valid", frame_valid, 1);
            chk("hold_data", frame_data, pd);
        end
        if (rst_n && frame_valid && frame_ready) begin
            if (sb.size() == 0) chk("sb_unexpected", frame_data, 4'hF + 1);
            else chk("sb_frame", frame_data, sb.pop_front());
        end
        pv   = rst_n && frame_valid;
        pd   = frame_data;
        pacc = frame_valid && frame_ready;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nv;
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; frame_ready = 1'b0;
        in_bits = 4'd0; start1 = 1'b0; ready1 = 1'b1; in1 = 4'd0;
        repeat (2) step();
        chk("rst_mux_s", mux_s, 0);
        chk("rst_mux_e", mux_e, 0);
        chk("rst_data", frame_data, 0);
        chk("rst_valid", frame_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid1", frame_valid1, 0);
        rst_n = 1'b1;
        step();

        // Basic scan, immediate accept
        in_bits = 4'b1010; frame_ready = 1'b1; start = 1'b1;
        sb.push_back(4'b1010);
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("t1_mux_s", mux_s, k / 2);
            chk("t1_mux_e", mux_e, 1);
            chk("t1_valid_lo", frame_valid, 0);
            step();
        end
        chk("t1_valid", frame_valid, 1);
        chk("t1_hold_e", mux_e, 0);
        step();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_valid", frame_valid, 0);

        // Backpressure
        frame_ready = 1'b0; in_bits = 4'b0101; start = 1'b1;
        sb.push_back(4'b0101);
        step();
        wait_v(0, -1, n);
        chk("t2_lat", n, 8);
        repeat (5) begin
            chk("t2_valid", frame_valid, 1);
            chk("t2_data", frame_data, 4'b0101);
            chk("t2_mux_e", mux_e, 0);
            chk("t2_busy", busy, 1);
            step();
        end
        frame_ready = 1'b1;
        step();
        chk("t2_acc_valid", frame_valid, 0);
        chk("t2_acc_busy", busy, 0);

        // Continuous rescan
        cont = 1'b1; in_bits = 4'b0110; start = 1'b1;
        sb.push_back(4'b0110);
        step();
        wait_v(0, -1, n);
        chk("t3_lat1", n, 8);
        in_bits = 4'b1001;
        sb.push_back(4'b1001);
        step();
        chk("t3_acc_valid", frame_valid, 0);
        chk("t3_rescan_busy", busy, 1);
        cont = 1'b0;
        wait_v(0, -1, n);
        chk("t3_lat2", n, 8);
        step();
        chk("t3_idle_busy", busy, 0);

        // Reset mid-scan
        in_bits = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("t4_ch2", mux_s, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_s", mux_s, 0);
        chk("t4_rst_e", mux_e, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_valid", frame_valid, 0);
        chk("t4_rst_data", frame_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        nv = 0;
        repeat (20) begin
            if (frame_valid) nv++;
            step();
        end
        chk("t4_no_frame", nv, 0);
        chk("t4_busy", busy, 0);

        // start ignored in SCAN and HOLD
        frame_ready = 1'b0; in_bits = 4'b1100; start = 1'b1;
        sb.push_back(4'b1100);
        step();
        wait_v(0, 3, n);
        chk("t5_lat", n, 8);
        start = 1'b1;
        repeat (2) step();
        start = 1'b0;
        chk("t5_valid", frame_valid, 1);
        chk("t5_data", frame_data, 4'b1100);
        frame_ready = 1'b1;
        step();
        chk("t5_acc_valid", frame_valid, 0);
        chk("t5_busy", busy, 0);
        nv = 0;
        repeat (12) begin
            if (frame_valid || busy) nv++;
            step();
        end
        chk("t5_no_restart", nv, 0);

        // DWELL=1 instance
        in1 = 4'b1111; start1 = 1'b1;
        step();
        start1 = 1'b0;
        wait_v(1, -1, n);
        chk("t6_lat", n, 4);
        chk("t6_data", frame_data1, 4'b1111);
        step();
        chk("t6_acc", frame_valid1, 0);
        in1 = 4'b0100; start1 = 1'b1;
        step();
        start1 = 1'b0;
        wait_v(1, -1, n);
        chk("t6_lat2", n, 4);
        chk("t6_data2", frame_data1, 4'b0100);
        step();

        chk("sb_left", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
